// File: rtl/serial_subtractor.sv
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial unsigned subtractor computing A - B modulo
//               2^WIDTH with a final borrow. One bit is processed per clock,
//               LSB first, using a single full-subtractor cell and a borrow
//               flop. Operands enter and results leave through
//               valid/ready handshakes.
//
// Parameters  : WIDTH      operand/result width in bits (2..32), default 8
//
// Ports       : clk        rising-edge clock
//               rst        synchronous active-high reset
//               in_valid   operand pair A/B present
//               in_ready   block can accept an operand pair (IDLE only)
//               A          minuend, unsigned
//               B          subtrahend, unsigned
//               diff       A - B modulo 2^WIDTH
//               borrow     final borrow out (1 iff A < B unsigned)
//               out_valid  diff/borrow valid (DONE only)
//               out_ready  consumer accepts the result
//               ovf        two's-complement overflow (only with the macro)
//
// Options     : SERIAL_SUB_OVF_EN  when defined, adds the ovf output.
//
// Timing      : out_valid rises exactly WIDTH cycles after the accepting
//               edge. The handshake edge returns to IDLE, so back-to-back
//               operations accept every WIDTH+2 cycles.
//
// Revision    : 1.0  initial release
// ============================================================================

`default_nettype none

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             out_valid,
    input  logic             out_ready
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    // Counter must be able to hold WIDTH itself after the final shift.
    localparam int C_CNT_W = $clog2(WIDTH + 1);
    localparam logic [C_CNT_W-1:0] C_LAST_BIT = C_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   diff_q;
    logic               borrow_q;      // doubles as the serial borrow-in
    logic [C_CNT_W-1:0] cnt_q;

    // Full-subtractor cell operating on the current LSBs.
    logic               w_a_bit;
    logic               w_b_bit;
    logic               w_d_bit;
    logic               w_bout;

    logic [WIDTH-1:0]   a_d;
    logic [WIDTH-1:0]   b_d;
    logic [WIDTH-1:0]   diff_d;
    logic [C_CNT_W-1:0] cnt_d;

    assign w_a_bit = a_q[0];
    assign w_b_bit = b_q[0];
    assign w_d_bit = w_a_bit ^ w_b_bit ^ borrow_q;
    assign w_bout  = (~w_a_bit & w_b_bit) | (~(w_a_bit ^ w_b_bit) & borrow_q);

    // Operands move right so the next bit is always at index 0; result bits
    // enter from the MSB side so after WIDTH shifts bit 0 lands at diff[0].
    assign a_d    = {1'b0, a_q[WIDTH-1:1]};
    assign b_d    = {1'b0, b_q[WIDTH-1:1]};
    assign diff_d = {w_d_bit, diff_q[WIDTH-1:1]};
    assign cnt_d  = cnt_q + C_CNT_W'(1);

`ifdef SERIAL_SUB_OVF_EN
    // Operand sign bits captured at accept; the shift registers lose them.
    logic a_msb_q;
    logic b_msb_q;
    logic ovf_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
            cnt_q       <= '0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    // diff/borrow intentionally hold their last result here.
                    if (in_valid) begin
                        a_q        <= A;
                        b_q        <= B;
                        borrow_q   <= 1'b0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= SHIFT;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb_q    <= A[WIDTH-1];
                        b_msb_q    <= B[WIDTH-1];
`endif
                    end
                end

                SHIFT: begin
                    a_q      <= a_d;
                    b_q      <= b_d;
                    diff_q   <= diff_d;
                    borrow_q <= w_bout;
                    cnt_q    <= cnt_d;
                    if (cnt_q == C_LAST_BIT) begin
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
`ifdef SERIAL_SUB_OVF_EN
                        // w_d_bit is the bit about to become diff[MSB].
                        ovf_q <= (a_msb_q ^ b_msb_q) & (w_d_bit ^ a_msb_q);
`endif
                    end
                end

                DONE: begin
                    // Return to IDLE only; a new accept waits one more edge.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end

                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign borrow    = borrow_q;

`ifdef SERIAL_SUB_OVF_EN
    assign ovf = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none

module tb_serial_subtractor;

    localparam int WIDTH = 8;
    localparam logic [WIDTH-1:0] MASK = '1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             out_valid;
    logic             out_ready;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .diff      (diff),
        .borrow    (borrow),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             b;
        logic             o;
        int               acc;
    } exp_t;

    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: plain arithmetic subtraction.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int acc);
        exp_t e;
        e.d   = (a - b) & MASK;
        e.b   = (a < b);
        e.o   = (a[WIDTH-1] != b[WIDTH-1]) && (e.d[WIDTH-1] != a[WIDTH-1]);
        e.acc = acc;
        return e;
    endfunction

    // Called at posedge+#1; returns at accept edge +#1 with in_valid low.
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, output int acc);
        int n;
        in_valid = 1'b1;
        A = a;
        B = b;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("accept_timeout", in_ready, 1);
        acc = cyc + 1;
        sb.push_back(model(a, b, acc));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Wait (bounded) until scoreboard empty and block idle; ends at posedge+#1.
    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0 || !in_ready) chk("drain_timeout", sb.size(), 0);
    endtask

    // Output monitor: latency on out_valid rise, results at handshake.
    logic ov_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && !ov_prev) begin
                if (sb.size() == 0) chk("spurious_out_valid", out_valid, 1'b0);
                else                chk("latency", cyc - sb[0].acc, WIDTH);
            end
            if (out_valid && out_ready && sb.size() != 0) begin
                chk("diff", diff, sb[0].d);
                chk("borrow", borrow, sb[0].b);
`ifdef SERIAL_SUB_OVF_EN
                chk("ovf", ovf, sb[0].o);
`endif
                sb.delete(0);
            end
        end
        ov_prev <= out_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int prev_acc;
        int n;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_diff", diff, 0);
        chk("rst_borrow", borrow, 0);
        @(posedge clk); #1;
        rst       = 1'b0;
        out_ready = 1'b1;

        // Directed operands
        do_op(8'h05, 8'h03, acc); drain();
        do_op(8'h03, 8'h05, acc); drain();
        do_op(8'h00, 8'h00, acc); drain();
`ifdef SERIAL_SUB_OVF_EN
        do_op(8'h80, 8'h01, acc); drain();
        do_op(8'h7F, 8'h01, acc); drain();
`endif

        // Hold result in DONE with out_ready low; new operands must be ignored
        out_ready = 1'b0;
        do_op(8'h5A, 8'h21, acc);
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("hold_reach_done", out_valid, 1);
        @(posedge clk); #1;
        in_valid = 1'b1;
        A = 8'h11;
        B = 8'h22;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_diff", diff, 8'h39);
            chk("hold_borrow", borrow, 0);
            chk("hold_in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("post_hs_in_ready", in_ready, 1);
        chk("post_hs_out_valid", out_valid, 0);
        @(posedge clk); #1;
        drain();

        // Reset while shifting bit 3: operation aborted
        do_op(8'hAA, 8'h55, acc);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        repeat (12) @(negedge clk);
        chk("abort_no_result", out_valid, 0);
        @(posedge clk); #1;
        do_op(8'hFF, 8'h0F, acc); drain();

        // Back-to-back with in_valid held and out_ready high
        prev_acc = 0;
        for (int i = 0; i < 4; i++) begin
            ra = WIDTH'($urandom_range(0, 255));
            rb = WIDTH'($urandom_range(0, 255));
            do_op(ra, rb, acc);
            if (i > 0) chk("b2b_interval", acc - prev_acc, WIDTH + 2);
            prev_acc = acc;
        end
        drain();
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port: in_valid  input  1  operand pair A/B present.
REQ-005 The block SHALL have port: in_ready  output  1  block can accept an operand pair.
REQ-006 The block SHALL have port: A  input  WIDTH  minuend, unsigned.
REQ-007 The block SHALL have port: B  input  WIDTH  subtrahend, unsigned.
REQ-008 The block SHALL have port: diff  output  WIDTH  result A-B modulo 2^WIDTH.
REQ-009 The block SHALL have port: borrow  output  1  final borrow out; 1 iff A<B unsigned.
REQ-010 The block SHALL have port: out_valid  output  1  diff/borrow valid.
REQ-011 The block SHALL have port: out_ready  input  1  consumer accepts result.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-013 IDLE SHALL drive in_ready=1 and out_valid=0; in SHIFT and DONE, in_ready SHALL be 0.
REQ-014 An accept SHALL occur on a rising edge with in_valid=1 and in_ready=1; on accept, the block SHALL load A and B into shift registers, clear the borrow flop, clear the bit counter, and go to SHIFT.
REQ-015 Each SHIFT cycle SHALL process one bit, LSB first: d = a^b^bin; bout = (~a&b) | (~(a^b)&bin).
REQ-016 d SHALL be shifted into diff from the MSB side, and bout SHALL be registered as the next bin.
REQ-017 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide; after exactly WIDTH SHIFT cycles, the FSM SHALL go to DONE.
REQ-018 out_valid SHALL rise exactly WIDTH clock cycles after the accepting edge; borrow SHALL equal the last bout.
REQ-019 In DONE, out_valid=1 and diff/borrow SHALL hold stable until a rising edge with out_ready=1; that edge SHALL return the FSM to IDLE.
REQ-020 A new accept SHALL NOT occur on the same edge that completes the output handshake; the earliest next accept is the following edge.
REQ-021 in_valid SHALL be ignored outside IDLE; A and B SHALL be sampled only at accept.
REQ-022 out_ready SHALL be ignored outside DONE.
REQ-023 diff and borrow SHALL keep their last values in IDLE; they are meaningful only while out_valid=1.

Reset
REQ-024 With rst=1 at a rising edge, the block SHALL set FSM=IDLE, diff=0, borrow=0, out_valid=0 and counter=0; in_ready SHALL be 1 in the cycle after the reset edge.
REQ-025 Reset SHALL take priority over every other event, including an accept or an output handshake on the same edge.
REQ-026 Reset during SHIFT or DONE SHALL abort the operation; no out_valid pulse for it SHALL follow.

Configuration
REQ-027 When SERIAL_SUB_OVF_EN is defined, the block SHALL add port ovf (output, 1 bit): two's-complement overflow, (A[MSB]!=B[MSB]) && (diff[MSB]!=A[MSB]).
REQ-028 With SERIAL_SUB_OVF_EN defined, ovf SHALL be computed from the registered operand MSBs, be valid with out_valid, and reset to 0.
REQ-029 Without SERIAL_SUB_OVF_EN, the port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification (WIDTH=8)
REQ-030 The bench SHALL apply A=0x05, B=0x03 and check diff=0x02, borrow=0, with out_valid exactly 8 cycles after accept.
REQ-031 The bench SHALL apply A=0x03, B=0x05 and check diff=0xFE, borrow=1; also A=0x00, B=0x00 and check diff=0x00, borrow=0.
REQ-032 With SERIAL_SUB_OVF_EN defined, the bench SHALL apply A=0x80, B=0x01 and check diff=0x7F, borrow=0, ovf=1; and A=0x7F, B=0x01 and check ovf=0.
REQ-033 The bench SHALL hold out_ready=0 for 5 cycles in DONE and check out_valid/diff stable and in_ready=0, with in_valid=1 and a new A/B ignored; then pulse out_ready and check in_ready=1 on the next cycle.
REQ-034 The bench SHALL assert rst at SHIFT bit 3 and check out_valid=0 and in_ready=1 after the reset edge, then check that a fresh A=0xFF, B=0x0F gives diff=0xF0, borrow=0.
REQ-035 The bench SHALL run 4 back-to-back operations with out_ready=1 and in_valid=1 and check an accept every WIDTH+2 cycles with correct results.
